// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: command codes, frame sizes, FSM states.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W   = 10;
    localparam int DATA_W    = 8;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_TX,
        TURNAROUND,
        SHIFT_RX,
        HOLD,
        GAP
    } spi_state_e;

    // States in which SCLK is allowed to run.
    function automatic logic sclk_active(input spi_state_e s);
        return (s == SHIFT_TX) || (s == TURNAROUND) || (s == SHIFT_RX);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: high half-period first, then low; strobes mark the phase points
// the master acts on. Held low with the divider cleared while disabled.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_stb,    // first cycle of a high half
    output logic fall_stb,    // last cycle of a high half (SCLK falls after it)
    output logic period_stb   // last cycle of a low half (end of one SCLK period)
);

    localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             half_q, half_d;   // 0: high half, 1: low half
    logic             wrap;

    // Divider and half-period phase next-state.
    always_comb begin
        wrap   = (div_q == DIV_LAST);
        div_d  = div_q;
        half_d = half_q;
        if (!en) begin
            div_d  = '0;
            half_d = 1'b0;
        end else if (wrap) begin
            div_d  = '0;
            half_d = ~half_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            half_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            half_q <= half_d;
        end
    end

    assign sclk       = en & ~half_q;
    assign rise_stb   = en & ~half_q & (div_q == '0);
    assign fall_stb   = en & ~half_q & wrap;
    assign period_stb = en &  half_q & wrap;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: sends {cmd,din} MSB first and, for read-data, collects
// one response byte after a turnaround gap.
//
// state      | meaning
// IDLE       | waiting for start; SS_n high
// SETUP      | SS_n low, MOSI = frame MSB, CLK_DIV cycles before first SCLK
// SHIFT_TX   | 10 SCLK periods shifting the frame out
// TURNAROUND | TA_BITS idle SCLK periods before the response (read-data only)
// SHIFT_RX   | 8 SCLK periods sampling MISO
// HOLD       | SCLK low, SS_n still low, CLK_DIV cycles
// GAP        | SS_n high, busy high, CLK_DIV cycles
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int TA_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              SCLK,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int                   DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] TX_LAST  = BIT_CNT_W'(FRAME_W - 1);
    localparam logic [BIT_CNT_W-1:0] TA_LAST  = BIT_CNT_W'(TA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] RX_LAST  = BIT_CNT_W'(DATA_W - 1);

    spi_state_e           state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]    rx_q, rx_d;
    logic [DATA_W-1:0]    rd_q, rd_d;
    logic [1:0]           cmd_q, cmd_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [DIV_W-1:0]     wait_q, wait_d;
    logic                 done_q, done_d;

    logic sclk_en, rise_stb, fall_stb, period_stb, last_period;

    assign sclk_en     = sclk_active(state_q);
    assign last_period = period_stb && (bit_q == '0);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst),
        .en         (sclk_en),
        .sclk       (SCLK),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .period_stb (period_stb)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            cmd_q   <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            cmd_q   <= cmd_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = SETUP;
            SETUP:      if (wait_q == '0) state_d = SHIFT_TX;
            SHIFT_TX: begin
                if (last_period) begin
                    if (cmd_q != CMD_RD_DATA) state_d = HOLD;
                    else if (TA_BITS == 0)    state_d = SHIFT_RX;
                    else                      state_d = TURNAROUND;
                end
            end
            TURNAROUND: if (last_period) state_d = SHIFT_RX;
            SHIFT_RX:   if (last_period) state_d = HOLD;
            HOLD:       if (wait_q == '0) state_d = GAP;
            GAP:        if (wait_q == '0) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Shift registers, down-counters and the done pulse.
    always_comb begin
        shift_d = shift_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        cmd_d   = cmd_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        if (wait_q != '0) wait_d = wait_q - 1'b1;
        if (period_stb && (bit_q != '0)) bit_d = bit_q - 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {cmd, din};
                    cmd_d   = cmd;
                    wait_d  = DIV_LAST;
                end
            end
            SETUP: begin
                if (wait_q == '0) bit_d = TX_LAST;
            end
            SHIFT_TX: begin
                if (fall_stb) shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                if (state_d == TURNAROUND)    bit_d  = TA_LAST;
                else if (state_d == SHIFT_RX) bit_d  = RX_LAST;
                else if (state_d == HOLD)     wait_d = DIV_LAST;
            end
            TURNAROUND: begin
                if (state_d == SHIFT_RX) bit_d = RX_LAST;
            end
            SHIFT_RX: begin
                if (rise_stb) rx_d = {rx_q[DATA_W-2:0], MISO};
                // The last sample lands in the high half, so rx_q is complete here.
                if (state_d == HOLD) begin
                    rd_d   = rx_q;
                    wait_d = DIV_LAST;
                end
            end
            HOLD: begin
                if (wait_q == '0) begin
                    wait_d = DIV_LAST;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pin-level outputs decoded from state.
    always_comb begin
        busy = (state_q != IDLE);
        SS_n = (state_q == IDLE) || (state_q == GAP);
        MOSI = ((state_q == SETUP) || (state_q == SHIFT_TX)) ? shift_q[FRAME_W-1] : 1'b0;
    end

    assign done    = done_q;
    assign rd_data = rd_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=2 with a mode-0 slave
// model, one at CLK_DIV=1 for the fast-clock write case.
module tb_spi_master;

    localparam int LIMIT = 400;

    logic       clk;
    logic       rst;
    logic [1:0] start_v;
    logic [1:0] cmd;
    logic [7:0] din;
    logic [1:0] busy_w, done_w, sclk_w, ssn_w, mosi_w;
    logic [7:0] rd0, rd1;
    logic       miso0, miso1;

    int n_checks = 0;
    int n_errors = 0;

    // per-frame observations
    int         r_ss_low, r_ss_hi, r_rises, r_done, r_sclk_hi;
    int         r_first_rise, r_done_n, r_exit_n;
    logic [19:0] r_bits;
    logic [7:0] r_rd;
    logic       r_mosi_bad;
    logic       r_rst_ss, r_rst_sclk, r_rst_busy;
    logic [7:0] r_rst_rd;

    // slave model state
    int         srise;
    logic [7:0] slv_byte;

    spi_master #(.CLK_DIV(2), .TA_BITS(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .cmd(cmd), .din(din),
        .busy(busy_w[0]), .done(done_w[0]), .rd_data(rd0),
        .SCLK(sclk_w[0]), .SS_n(ssn_w[0]), .MOSI(mosi_w[0]), .MISO(miso0)
    );

    spi_master #(.CLK_DIV(1), .TA_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .cmd(cmd), .din(din),
        .busy(busy_w[1]), .done(done_w[1]), .rd_data(rd1),
        .SCLK(sclk_w[1]), .SS_n(ssn_w[1]), .MOSI(mosi_w[1]), .MISO(miso1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 slave: count rising SCLK edges in the frame, present the response
    // byte on falling edges once the turnaround periods are over.
    always @(posedge ssn_w[0] or posedge sclk_w[0]) begin
        if (ssn_w[0]) srise <= 0;
        else          srise <= srise + 1;
    end

    always @(negedge sclk_w[0]) begin
        if (srise >= 12 && srise < 20) miso0 <= slv_byte[19 - srise];
        else                           miso0 <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Run one frame on instance d, sampling every negedge from frame cycle 1.
    task automatic run_frame(input string tag, input int d, input logic [1:0] c,
                             input logic [7:0] dat, input bit skip_start,
                             input bit hold_start, input int poke_cyc, input int rst_cyc);
        logic prev_sck, seen_low, fin;
        r_ss_low = 0; r_ss_hi = 0; r_rises = 0; r_done = 0; r_sclk_hi = 0;
        r_first_rise = 0; r_done_n = 0; r_exit_n = 0;
        r_bits = '0; r_rd = '0; r_mosi_bad = 1'b0;
        prev_sck = 1'b0; seen_low = 1'b0; fin = 1'b0;
        if (!skip_start) begin
            @(negedge clk);
            cmd = c; din = dat; start_v[d] = 1'b1;
            @(negedge clk);
        end
        if (!hold_start) start_v[d] = 1'b0;
        for (int n = 1; n < LIMIT; n++) begin
            if (!ssn_w[d]) begin
                r_ss_low++;
                seen_low = 1'b1;
            end else if (seen_low) begin
                r_ss_hi++;
            end
            if (sclk_w[d]) r_sclk_hi++;
            if (sclk_w[d] && !prev_sck) begin
                if (r_rises == 0) r_first_rise = n;
                if (r_rises < 20) r_bits[19 - r_rises] = mosi_w[d];
                r_rises++;
            end
            if (!ssn_w[d] && (r_rises > 10 || (r_rises == 10 && !sclk_w[d])) && mosi_w[d])
                r_mosi_bad = 1'b1;
            if (done_w[d]) begin
                r_done++;
                r_done_n = n;
                r_rd = (d == 0) ? rd0 : rd1;
            end
            prev_sck = sclk_w[d];
            if (n == rst_cyc) begin
                rst = 1'b0;
                #1;
                r_rst_ss   = ssn_w[d];
                r_rst_sclk = sclk_w[d];
                r_rst_busy = busy_w[d];
                r_rst_rd   = (d == 0) ? rd0 : rd1;
                fin = 1'b1;
                break;
            end
            if (!busy_w[d]) begin
                r_exit_n = n;
                fin = 1'b1;
                break;
            end
            if (n == poke_cyc) begin
                start_v[d] = 1'b1;
                cmd = ~c;
                din = ~dat;
            end
            if (n == poke_cyc + 1 && !hold_start) start_v[d] = 1'b0;
            @(negedge clk);
        end
        check({tag, "_finished"}, 32'(fin), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b0; start_v = '0; cmd = '0; din = '0; miso1 = 1'b0;
        slv_byte = 8'hA5;
        repeat (2) @(negedge clk);
        check("rst_ssn",  32'(ssn_w),  32'h3);
        check("rst_sclk", 32'(sclk_w), 32'h0);
        check("rst_mosi", 32'(mosi_w), 32'h0);
        check("rst_busy", 32'(busy_w), 32'h0);
        check("rst_done", 32'(done_w), 32'h0);
        check("rst_rd",   32'({rd1, rd0}), 32'h0);
        rst = 1'b1;

        // write address 3C
        run_frame("wr3c", 0, 2'b00, 8'h3C, 0, 0, -1, -1);
        check("wr3c_bits",    32'(r_bits[19:10]), 32'h03C);
        check("wr3c_rises",   r_rises, 10);
        check("wr3c_ss_low",  r_ss_low, 44);
        check("wr3c_sclk_hi", r_sclk_hi, 20);
        check("wr3c_first",   r_first_rise, 3);
        check("wr3c_done",    r_done, 1);
        check("wr3c_done_n",  r_done_n, 45);
        check("wr3c_busy_lo", r_exit_n, 47);
        check("wr3c_rd",      32'(rd0), 32'h00);

        // read data, slave answers A5
        run_frame("rd", 0, 2'b11, 8'h96, 0, 0, -1, -1);
        check("rd_bits",    32'(r_bits[19:10]), 32'h396);
        check("rd_bits_lo", 32'(r_bits[9:0]), 32'h000);
        check("rd_rises",   r_rises, 20);
        check("rd_ss_low",  r_ss_low, 84);
        check("rd_done",    r_done, 1);
        check("rd_busy_lo", r_exit_n - r_done_n, 2);
        check("rd_data",    32'(r_rd), 32'hA5);
        check("rd_mosi0",   32'(r_mosi_bad), 32'h0);

        // back-to-back with start held high, inputs changed mid-frame
        run_frame("b2b1", 0, 2'b01, 8'h5A, 0, 1, 20, -1);
        check("b2b1_bits",  32'(r_bits[19:10]), 32'h15A);
        check("b2b1_ss_hi", r_ss_hi, 3);
        check("b2b1_rd",    32'(rd0), 32'hA5);
        @(negedge clk);
        check("b2b2_start", 32'({busy_w[0], ssn_w[0]}), 32'h2);
        start_v[0] = 1'b0;
        run_frame("b2b2", 0, 2'b10, 8'hA5, 1, 0, -1, -1);
        check("b2b2_bits", 32'(r_bits[19:10]), 32'h2A5);
        check("b2b2_done", r_done, 1);
        check("b2b2_rd",   32'(rd0), 32'hA5);

        // start pulsed during SHIFT_TX
        run_frame("pulse", 0, 2'b10, 8'h81, 0, 0, 10, -1);
        check("pulse_bits", 32'(r_bits[19:10]), 32'h281);
        check("pulse_done", r_done, 1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (!ssn_w[0] || busy_w[0]) cnt++;
        end
        check("pulse_no_second", cnt, 0);

        // reset during the 5th bit of a read-data frame
        run_frame("rstmid", 0, 2'b11, 8'h00, 0, 0, -1, 20);
        check("rstmid_rises", r_rises, 5);
        check("rstmid_ssn",   32'(r_rst_ss), 32'h1);
        check("rstmid_sclk",  32'(r_rst_sclk), 32'h0);
        check("rstmid_busy",  32'(r_rst_busy), 32'h0);
        check("rstmid_rd",    32'(r_rst_rd), 32'h00);
        cnt = r_done;
        repeat (3) begin
            @(negedge clk);
            if (done_w[0]) cnt++;
        end
        check("rstmid_no_done", cnt, 0);
        rst = 1'b1;
        run_frame("post", 0, 2'b10, 8'h42, 0, 0, -1, -1);
        check("post_bits",   32'(r_bits[19:10]), 32'h242);
        check("post_ss_low", r_ss_low, 44);
        check("post_done",   r_done, 1);
        check("post_rd",     32'(rd0), 32'h00);

        // CLK_DIV = 1 write data FF
        run_frame("div1", 1, 2'b01, 8'hFF, 0, 0, -1, -1);
        check("div1_bits",    32'(r_bits[19:10]), 32'h1FF);
        check("div1_rises",   r_rises, 10);
        check("div1_sclk_hi", r_sclk_hi, 10);
        check("div1_first",   r_first_rise, 2);
        check("div1_ss_low",  r_ss_low, 22);
        check("div1_done",    r_done, 1);
        check("div1_busy_lo", r_exit_n - r_done_n, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
